// File: rtl/jtag_dmi_bridge_if.sv
// rtl/jtag_dmi_bridge_if.sv - JTAG pin and DMI request/response bundle for jtag_dmi_bridge
// master is the bridge side; slave is the pad/debug-module side.
interface jtag_dmi_bridge_if #(
    parameter int unsigned DMI_ABITS = 7
);
    logic                 jtag_tck_i;
    logic                 jtag_tms_i;
    logic                 jtag_tdi_i;
    logic                 jtag_trst_ni;
    logic                 jtag_tdo_o;
    logic                 dmi_req_valid_o;
    logic                 dmi_req_ready_i;
    logic [DMI_ABITS-1:0] dmi_req_addr_o;
    logic [1:0]           dmi_req_op_o;
    logic [31:0]          dmi_req_data_o;
    logic                 dmi_rsp_valid_i;
    logic                 dmi_rsp_ready_o;
    logic [31:0]          dmi_rsp_data_i;
    logic [1:0]           dmi_rsp_resp_i;
    logic                 dmi_rst_no;

    modport master (
        input  jtag_tck_i, jtag_tms_i, jtag_tdi_i, jtag_trst_ni,
        input  dmi_req_ready_i, dmi_rsp_valid_i, dmi_rsp_data_i, dmi_rsp_resp_i,
        output jtag_tdo_o, dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o,
        output dmi_req_data_o, dmi_rsp_ready_o, dmi_rst_no
    );

    modport slave (
        output jtag_tck_i, jtag_tms_i, jtag_tdi_i, jtag_trst_ni,
        output dmi_req_ready_i, dmi_rsp_valid_i, dmi_rsp_data_i, dmi_rsp_resp_i,
        input  jtag_tdo_o, dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o,
        input  dmi_req_data_o, dmi_rsp_ready_o, dmi_rst_no
    );
endinterface

// File: rtl/jtag_dmi_bridge.sv
// rtl/jtag_dmi_bridge.sv - oversampled JTAG TAP with RISC-V DTM registers bridged to a DMI port
// Optional JTAG_DMI_BRIDGE_TIMEOUT_EN aborts a DMI response wait after RSP_TIMEOUT cycles.
module jtag_dmi_bridge #(
    parameter int unsigned IR_WIDTH    = 5,
    parameter logic [31:0] IDCODE      = 32'h04F5484D,
    parameter int unsigned DMI_ABITS   = 7,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RSP_TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset_i,
    jtag_dmi_bridge_if.master bus
);
    localparam int DR_W  = DMI_ABITS + 34;
    localparam int DR_IW = $clog2(DR_W);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_DTMCS  = IR_WIDTH'(16);
    localparam logic [IR_WIDTH-1:0] IR_DMI    = IR_WIDTH'(17);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_e;
    typedef enum logic [1:0] {B_IDLE, B_REQ, B_RSP} bst_e;

    logic [SYNC_STAGES-1:0] r_tck_s, r_tms_s, r_tdi_s, r_trst_s;
    logic                   r_tck_d, r_tdo, r_dmi_rst_n;
    tap_e                   r_tap, w_tap_next;
    bst_e                   r_bst, w_bnext;
    logic [IR_WIDTH-1:0]    r_ir, r_ir_sh;
    logic [DR_W-1:0]        r_dr, w_dr_cap, w_dr_shift;
    logic [DR_IW-1:0]       w_dr_msb;
    logic [DMI_ABITS-1:0]   r_addr;
    logic [31:0]            r_wdata, r_rdata;
    logic [1:0]             r_op, r_dmistat, w_opfield;
    logic w_tck, w_tms, w_tdi, w_trst_n, w_rise, w_fall, w_upd_dr, w_busy;
    logic w_dmi_go, w_accept, w_busy_err, w_hardreset, w_dmireset, w_rsp_done, w_rsp_err, w_timeout;

    assign w_tck    = r_tck_s[SYNC_STAGES-1];
    assign w_tms    = r_tms_s[SYNC_STAGES-1];
    assign w_tdi    = r_tdi_s[SYNC_STAGES-1];
    assign w_trst_n = r_trst_s[SYNC_STAGES-1];
    assign w_rise   = w_tck & ~r_tck_d & w_trst_n;
    assign w_fall   = ~w_tck & r_tck_d;

    always_ff @(posedge clock) begin
        if (reset_i) begin
            r_tck_s  <= '0;
            r_tms_s  <= '0;
            r_tdi_s  <= '0;
            r_trst_s <= '0;
            r_tck_d  <= 1'b0;
        end else begin
            r_tck_s  <= {r_tck_s[SYNC_STAGES-2:0], bus.jtag_tck_i};
            r_tms_s  <= {r_tms_s[SYNC_STAGES-2:0], bus.jtag_tms_i};
            r_tdi_s  <= {r_tdi_s[SYNC_STAGES-2:0], bus.jtag_tdi_i};
            r_trst_s <= {r_trst_s[SYNC_STAGES-2:0], bus.jtag_trst_ni};
            r_tck_d  <= w_tck;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_i) r_tap <= TLR;
        else         r_tap <= w_tap_next;
    end

    always_comb begin
        w_tap_next = r_tap;
        if (!w_trst_n) begin
            w_tap_next = TLR;
        end else if (w_rise) begin
            case (r_tap)
                TLR:    w_tap_next = w_tms ? TLR    : RTI;
                RTI:    w_tap_next = w_tms ? SEL_DR : RTI;
                SEL_DR: w_tap_next = w_tms ? SEL_IR : CAP_DR;
                CAP_DR: w_tap_next = w_tms ? EX1_DR : SH_DR;
                SH_DR:  w_tap_next = w_tms ? EX1_DR : SH_DR;
                EX1_DR: w_tap_next = w_tms ? UPD_DR : PA_DR;
                PA_DR:  w_tap_next = w_tms ? EX2_DR : PA_DR;
                EX2_DR: w_tap_next = w_tms ? UPD_DR : SH_DR;
                UPD_DR: w_tap_next = w_tms ? SEL_DR : RTI;
                SEL_IR: w_tap_next = w_tms ? TLR    : CAP_IR;
                CAP_IR: w_tap_next = w_tms ? EX1_IR : SH_IR;
                SH_IR:  w_tap_next = w_tms ? EX1_IR : SH_IR;
                EX1_IR: w_tap_next = w_tms ? UPD_IR : PA_IR;
                PA_IR:  w_tap_next = w_tms ? EX2_IR : PA_IR;
                EX2_IR: w_tap_next = w_tms ? UPD_IR : SH_IR;
                UPD_IR: w_tap_next = w_tms ? SEL_DR : RTI;
                default: w_tap_next = TLR;
            endcase
        end
    end

    assign w_busy    = (r_bst != B_IDLE);
    assign w_opfield = (r_dmistat != 2'd0) ? r_dmistat : (w_busy ? 2'd3 : 2'd0);

    // One shared DR; the active length only moves the TDI insertion point.
    always_comb begin
        w_dr_cap = '0;
        w_dr_msb = '0;
        if (r_ir == IR_IDCODE) begin
            w_dr_cap = DR_W'(IDCODE);
            w_dr_msb = DR_IW'(31);
        end else if (r_ir == IR_DTMCS) begin
            w_dr_cap = DR_W'({17'd0, 3'd1, r_dmistat, 6'(DMI_ABITS), 4'd1});
            w_dr_msb = DR_IW'(31);
        end else if (r_ir == IR_DMI) begin
            w_dr_cap = {r_addr, r_rdata, w_opfield};
            w_dr_msb = DR_IW'(DR_W - 1);
        end
        w_dr_shift = r_dr >> 1;
        w_dr_shift[w_dr_msb] = w_tdi;
    end

    always_ff @(posedge clock) begin
        if (reset_i) begin
            r_ir    <= IR_IDCODE;
            r_ir_sh <= '0;
            r_dr    <= '0;
            r_tdo   <= 1'b0;
        end else begin
            if (w_rise) begin
                case (r_tap)
                    CAP_IR:  r_ir_sh <= IR_WIDTH'(1);
                    SH_IR:   r_ir_sh <= {w_tdi, r_ir_sh[IR_WIDTH-1:1]};
                    UPD_IR:  r_ir    <= r_ir_sh;
                    CAP_DR:  r_dr    <= w_dr_cap;
                    SH_DR:   r_dr    <= w_dr_shift;
                    default: ;
                endcase
            end
            if (w_fall)
                r_tdo <= (r_tap == SH_IR) ? r_ir_sh[0] : (r_tap == SH_DR) ? r_dr[0] : 1'b0;
            if (!w_trst_n || r_tap == TLR)
                r_ir <= IR_IDCODE;
        end
    end

    assign w_upd_dr    = w_rise && (r_tap == UPD_DR);
    assign w_dmi_go    = w_upd_dr && (r_ir == IR_DMI) && (r_dr[1:0] == 2'd1 || r_dr[1:0] == 2'd2);
    assign w_accept    = w_dmi_go && !w_busy && (r_dmistat == 2'd0);
    assign w_busy_err  = w_dmi_go && w_busy;
    assign w_hardreset = w_upd_dr && (r_ir == IR_DTMCS) && r_dr[17];
    assign w_dmireset  = w_upd_dr && (r_ir == IR_DTMCS) && r_dr[16];
    assign w_rsp_done  = (r_bst == B_RSP) && bus.dmi_rsp_valid_i;
    assign w_rsp_err   = w_rsp_done && (bus.dmi_rsp_resp_i != 2'd0);

`ifdef JTAG_DMI_BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(RSP_TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;
    always_ff @(posedge clock) begin
        if (reset_i || r_bst != B_RSP) r_to_cnt <= '0;
        else                           r_to_cnt <= r_to_cnt + TO_W'(1);
    end
    assign w_timeout = (r_bst == B_RSP) && !bus.dmi_rsp_valid_i &&
                       (r_to_cnt == TO_W'(RSP_TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^RSP_TIMEOUT;
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset_i) r_bst <= B_IDLE;
        else         r_bst <= w_bnext;
    end

    always_comb begin
        w_bnext = r_bst;
        case (r_bst)
            B_IDLE:  if (w_accept) w_bnext = B_REQ;
            B_REQ:   if (bus.dmi_req_ready_i) w_bnext = B_RSP;
            B_RSP:   if (w_rsp_done || w_timeout) w_bnext = B_IDLE;
            default: w_bnext = B_IDLE;
        endcase
        if (w_hardreset) w_bnext = B_IDLE;
    end

    // A nonzero dmistat is sticky; busy collisions outrank response errors.
    always_ff @(posedge clock) begin
        if (reset_i) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_op        <= '0;
            r_rdata     <= '0;
            r_dmistat   <= '0;
            r_dmi_rst_n <= 1'b1;
        end else begin
            if (w_accept) begin
                r_addr  <= r_dr[DR_W-1:34];
                r_wdata <= r_dr[33:2];
                r_op    <= r_dr[1:0];
            end
            if (w_rsp_done) r_rdata <= bus.dmi_rsp_data_i;
            r_dmi_rst_n <= !w_hardreset;
            if (w_hardreset || w_dmireset)  r_dmistat <= 2'd0;
            else if (r_dmistat == 2'd0) begin
                if (w_busy_err)                  r_dmistat <= 2'd3;
                else if (w_rsp_err || w_timeout) r_dmistat <= 2'd2;
            end
        end
    end

    assign bus.jtag_tdo_o      = r_tdo;
    assign bus.dmi_req_valid_o = (r_bst == B_REQ);
    assign bus.dmi_rsp_ready_o = (r_bst == B_RSP);
    assign bus.dmi_req_addr_o  = r_addr;
    assign bus.dmi_req_op_o    = r_op;
    assign bus.dmi_req_data_o  = r_wdata;
    assign bus.dmi_rst_no      = r_dmi_rst_n;
endmodule

// File: tb/tb_jtag_dmi_bridge.sv
// tb/tb_jtag_dmi_bridge.sv - directed self-checking bench for jtag_dmi_bridge
module tb_jtag_dmi_bridge;
    logic clock = 1'b0;
    logic reset_i;
    int   total = 0;
    int   bad   = 0;
    int   n_req = 0;
    int   n_rst_low = 0;
    logic valid_d = 1'b0;
    logic [63:0] d;
    int   k;

    jtag_dmi_bridge_if #(.DMI_ABITS(7)) bus ();

    jtag_dmi_bridge dut (
        .clock   (clock),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.dmi_req_valid_o && !valid_d) n_req++;
        valid_d = bus.dmi_req_valid_o;
        if (!bus.dmi_rst_no) n_rst_low++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dmi(input logic [6:0] a, input logic [31:0] dat, input logic [1:0] op);
        return {23'd0, a, dat, op};
    endfunction

    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
        bus.jtag_tms_i = tms;
        bus.jtag_tdi_i = tdi;
        repeat (4) @(negedge clock);
        tdo = bus.jtag_tdo_o;
        bus.jtag_tck_i = 1'b1;
        repeat (4) @(negedge clock);
        bus.jtag_tck_i = 1'b0;
    endtask

    task automatic tap_reset();
        logic t;
        repeat (5) tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
    endtask

    task automatic shift_ir(input logic [4:0] ir, output logic [63:0] dout);
        logic t;
        dout = '0;
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        for (int i = 0; i < 5; i++) begin
            tck_cycle(i == 4, ir[i], t);
            dout[i] = t;
        end
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        repeat (4) @(negedge clock);
    endtask

    task automatic shift_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
        logic t;
        dout = '0;
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], t);
            dout[i] = t;
        end
        tck_cycle(1'b1, 1'b0, t);
        tck_cycle(1'b0, 1'b0, t);
        repeat (4) @(negedge clock);
    endtask

    task automatic wait_rsp_ready(input string tag);
        int n = 0;
        while (!bus.dmi_rsp_ready_o && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk(tag, bus.dmi_rsp_ready_o, 1);
    endtask

    task automatic respond(input logic [31:0] dat, input logic [1:0] resp);
        bus.dmi_rsp_valid_i = 1'b1;
        bus.dmi_rsp_data_i  = dat;
        bus.dmi_rsp_resp_i  = resp;
        @(negedge clock);
        bus.dmi_rsp_valid_i = 1'b0;
        bus.dmi_rsp_resp_i  = 2'd0;
    endtask

    initial begin
        logic t;
        bus.jtag_tck_i = 1'b0; bus.jtag_tms_i = 1'b1; bus.jtag_tdi_i = 1'b0;
        bus.jtag_trst_ni = 1'b1; bus.dmi_req_ready_i = 1'b0; bus.dmi_rsp_valid_i = 1'b0;
        bus.dmi_rsp_data_i = '0; bus.dmi_rsp_resp_i = '0;
        reset_i = 1'b1;
        repeat (4) @(negedge clock);
        reset_i = 1'b0;
        @(negedge clock);
        chk("rst_tdo", bus.jtag_tdo_o, 0);
        chk("rst_req_valid", bus.dmi_req_valid_o, 0);
        chk("rst_rsp_ready", bus.dmi_rsp_ready_o, 0);
        chk("rst_addr_op_data", {bus.dmi_req_addr_o, bus.dmi_req_op_o, bus.dmi_req_data_o}, 0);
        chk("rst_dmi_rst_no", bus.dmi_rst_no, 1);

        tap_reset();
        shift_dr(64'd0, 32, d);
        chk("idcode", d, 64'h04F5484D);

        shift_ir(5'h1F, d);
        chk("ir_capture", d, 64'h1);
        shift_dr(64'h0A5, 9, d);
        chk("bypass_delay", d, 64'h14A);

        shift_ir(5'h10, d);
        shift_dr(64'd0, 32, d);
        chk("dtmcs_read", d, 64'h1071);
        k = n_rst_low;
        shift_dr(64'h20000, 32, d);
        chk("hardreset_pulse_len", 64'(n_rst_low - k), 1);

        shift_ir(5'h11, d);
        k = n_req;
        shift_dr(dmi(7'h10, 32'h1, 2'd2), 41, d);
        chk("wr_one_req", 64'(n_req - k), 1);
        for (int i = 0; i < 3; i++) begin
            chk("wr_valid_hold", bus.dmi_req_valid_o, 1);
            chk("wr_fields", {bus.dmi_req_addr_o, bus.dmi_req_data_o, bus.dmi_req_op_o}, dmi(7'h10, 32'h1, 2'd2));
            @(negedge clock);
        end
        bus.dmi_req_ready_i = 1'b1;
        @(negedge clock);
        bus.dmi_req_ready_i = 1'b0;
        chk("wr_valid_drop", bus.dmi_req_valid_o, 0);
        chk("wr_rsp_ready", bus.dmi_rsp_ready_o, 1);
        respond(32'h0, 2'd0);
        chk("wr_idle", bus.dmi_rsp_ready_o, 0);

        bus.dmi_req_ready_i = 1'b1;
        shift_dr(dmi(7'h11, 32'h0, 2'd1), 41, d);
        wait_rsp_ready("rd_rsp_ready");
        chk("rd_fields", {bus.dmi_req_addr_o, bus.dmi_req_op_o}, {7'h11, 2'd1});
        respond(32'hDEADBEEF, 2'd0);
        shift_dr(64'd0, 41, d);
        chk("rd_capture", d, dmi(7'h11, 32'hDEADBEEF, 2'd0));

        shift_dr(dmi(7'h12, 32'h0, 2'd1), 41, d);
        wait_rsp_ready("busy_rsp_ready");
        k = n_req;
        shift_dr(dmi(7'h13, 32'h0, 2'd1), 41, d);
        chk("busy_capture_op", d[1:0], 3);
        chk("busy_no_req", 64'(n_req - k), 0);
        respond(32'h12345678, 2'd0);
        shift_ir(5'h10, d);
        shift_dr(64'd0, 32, d);
        chk("dtmcs_busy_stat", d, 64'h1C71);
        shift_dr(64'h10000, 32, d);
        shift_dr(64'd0, 32, d);
        chk("dtmcs_dmireset", d, 64'h1071);

        shift_ir(5'h11, d);
        shift_dr(dmi(7'h05, 32'h0, 2'd1), 41, d);
        wait_rsp_ready("err_rsp_ready");
        respond(32'hCAFEF00D, 2'd2);
        k = n_req;
        shift_dr(dmi(7'h07, 32'h0, 2'd1), 41, d);
        chk("err_capture", d, dmi(7'h05, 32'hCAFEF00D, 2'd2));
        chk("err_blocks_req", 64'(n_req - k), 0);
        shift_ir(5'h10, d);
        shift_dr(64'h10000, 32, d);
        chk("dtmcs_err_stat", d, 64'h1871);
        shift_dr(64'd0, 32, d);
        chk("dtmcs_err_cleared", d, 64'h1071);

        bus.dmi_req_ready_i = 1'b0;
        shift_ir(5'h11, d);
        shift_dr(dmi(7'h20, 32'hAA, 2'd2), 41, d);
        chk("abort_pending", bus.dmi_req_valid_o, 1);
        shift_ir(5'h10, d);
        shift_dr(64'h20000, 32, d);
        chk("abort_valid", bus.dmi_req_valid_o, 0);
        chk("abort_rsp_ready", bus.dmi_rsp_ready_o, 0);

        bus.jtag_trst_ni = 1'b0;
        repeat (5) @(negedge clock);
        bus.jtag_trst_ni = 1'b1;
        repeat (4) @(negedge clock);
        tck_cycle(1'b0, 1'b0, t);
        shift_dr(64'd0, 32, d);
        chk("trst_idcode", d, 64'h04F5484D);

        shift_ir(5'h11, d);
        shift_dr(dmi(7'h33, 32'h55, 2'd1), 41, d);
        chk("midrst_pending", bus.dmi_req_valid_o, 1);
        reset_i = 1'b1;
        @(negedge clock);
        chk("midrst_valid", bus.dmi_req_valid_o, 0);
        chk("midrst_fields", {bus.dmi_req_addr_o, bus.dmi_req_op_o, bus.dmi_req_data_o}, 0);
        chk("midrst_rst_no", bus.dmi_rst_no, 1);
        reset_i = 1'b0;
        repeat (2) @(negedge clock);

`ifdef JTAG_DMI_BRIDGE_TIMEOUT_EN
        tck_cycle(1'b0, 1'b0, t);
        shift_ir(5'h11, d);
        bus.dmi_req_ready_i = 1'b1;
        shift_dr(dmi(7'h44, 32'h0, 2'd1), 41, d);
        wait_rsp_ready("to_rsp_ready");
        repeat (1030) @(negedge clock);
        chk("to_rsp_ready_drop", bus.dmi_rsp_ready_o, 0);
        respond(32'h1, 2'd0);
        shift_dr(64'd0, 41, d);
        chk("to_capture", d, dmi(7'h44, 32'h0, 2'd2));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jtag_dmi_bridge.md
Name: jtag_dmi_bridge

Overview:
Parametrised JTAG Debug Transport Module that replaces the fixed external TAP path used by the simulation top. It oversamples JTAG pins in the system clock domain, runs a full IEEE 1149.1 TAP, and exposes the RISC-V DTM registers (IDCODE, DTMCS, DMI, BYPASS). DMI accesses are bridged to a valid/ready DMI request/response port on rv_dm. It sits between the jtagdpi/pad JTAG pins and the debug module.

Parameters:
IR_WIDTH, 5, instruction register width (>=5)
IDCODE, 32'h04F5484D, value shifted out for the IDCODE instruction; bit 0 must be 1
DMI_ABITS, 7, DMI address width (7..16)
SYNC_STAGES, 2, synchroniser depth on tck/tms/tdi/trst_n (>=2)
RSP_TIMEOUT, 1024, system-clock cycles to wait for dmi_rsp_valid_i (used only with the optional feature)

Ports:
clock  in  1  system clock; all logic on its rising edge
reset_i  in  1  synchronous, active-high reset
jtag_tck_i  in  1  JTAG TCK, asynchronous, oversampled
jtag_tms_i  in  1  JTAG TMS
jtag_tdi_i  in  1  JTAG TDI
jtag_trst_ni  in  1  JTAG TRST, active low
jtag_tdo_o  out  1  JTAG TDO
dmi_req_valid_o  out  1  DMI request valid
dmi_req_ready_i  in  1  DMI request ready
dmi_req_addr_o  out  DMI_ABITS  DMI address
dmi_req_op_o  out  2  DMI op: 1 = read, 2 = write
dmi_req_data_o  out  32  DMI write data
dmi_rsp_valid_i  in  1  DMI response valid
dmi_rsp_ready_o  out  1  DMI response ready
dmi_rsp_data_i  in  32  DMI response data
dmi_rsp_resp_i  in  2  DMI response status; 0 = OK
dmi_rst_no  out  1  one-cycle active-low DMI reset pulse

Behaviour:
- Reset values: jtag_tdo_o=0, dmi_req_valid_o=0, dmi_rsp_ready_o=0, dmi_req_addr_o/op/data=0, dmi_rst_no=1. TAP=Test-Logic-Reset. IR=IDCODE. Sticky dmistat=0. Bridge FSM=IDLE.
- Pins: pass through SYNC_STAGES flops. TCK rise and fall are detected from the last two synchronised samples.
- TCK rise: advance the 16-state TAP FSM on the synchronised TMS, and shift TDI in Shift-IR/Shift-DR (LSB first).
- TCK fall: update jtag_tdo_o from the selected shift register LSB. Outside Shift-IR/DR, hold TDO at 0.
- Synchronised trst_n=0 forces Test-Logic-Reset and IR=IDCODE immediately. Five TCK rises with TMS=1 from any state also reach Test-Logic-Reset.
- Capture-IR loads IR_WIDTH'b...01. Update-IR latches the IR.
- IR decode: 0x01 IDCODE (32 bits), 0x10 DTMCS (32 bits), 0x11 DMI (DMI_ABITS+34 bits), any other value BYPASS (1 bit, captures 0).
- DTMCS capture layout:
  - [3:0] version = 1
  - [9:4] abits = DMI_ABITS
  - [11:10] dmistat
  - [14:12] idle = 1
- DTMCS update:
  - bit16 (dmireset) clears dmistat.
  - bit17 (dmihardreset) clears dmistat, aborts the bridge to IDLE, and drives dmi_rst_no=0 for exactly one clock.
- DMI shift layout: {addr[DMI_ABITS+33:34], data[33:2], op[1:0]}.
- DMI Capture-DR loads {last addr, last rsp data, op field}:
  - op field = dmistat if dmistat != 0.
  - Otherwise op field = 3 while the bridge is busy, else 0.
- DMI Update-DR:
  - op 1 or 2 with bridge IDLE and dmistat=0: latch addr/data/op and enter REQ.
  - op 1 or 2 while busy: set dmistat=3; no request is issued.
  - op 0 or 3: no action.
- Bridge FSM:
  - IDLE -> REQ on an accepted Update-DR. dmi_req_valid_o=1 in the next cycle; outputs are stable until the handshake.
  - REQ -> RSP on valid&ready. dmi_rsp_ready_o=1 while in RSP.
  - RSP -> IDLE on dmi_rsp_valid_i. Latch rsp data. If dmi_rsp_resp_i != 0, set dmistat=2 (sticky).
- Simultaneous Update-DR and response completion in the same cycle: the FSM is treated as busy, so busy error 3 is set.
- dmistat values are sticky. A later error does not overwrite a nonzero dmistat.
- reset_i mid-transaction: everything returns to reset values on the next edge; the pending request is dropped.

Optional Feature:
JTAG_DMI_BRIDGE_TIMEOUT_EN
- Defined: a counter runs in RSP. After RSP_TIMEOUT cycles without dmi_rsp_valid_i, it sets dmistat=2, deasserts dmi_rsp_ready_o, and returns to IDLE. A late response is ignored.
- Undefined: no counter; RSP waits indefinitely.

Test Plan:
- Reset, TMS=1 x5, select IDCODE, shift 32 DR bits -> TDO stream = 0x04F5484D, LSB first.
- IR=0x1F, shift 0xA5 pattern through DR -> TDO equals TDI delayed by exactly one TCK.
- Read DTMCS -> 0x00001071. Write DTMCS bit17 -> dmi_rst_no low for 1 clock.
- DMI shift addr 0x10, data 0x00000001, op 2, with dmi_req_ready_i low for 3 clocks:
  - valid held with stable addr/data/op until ready.
  - Then rsp_ready=1; rsp_valid with resp 0 returns to IDLE.
- DMI read addr 0x11; responder returns 0xDEADBEEF with resp 0 -> next DMI capture shifts out addr 0x11, data 0xDEADBEEF, op 0.
- Update-DR while in RSP -> dmistat=3, no second dmi_req_valid_o. DTMCS dmireset clears dmistat to 0. With the macro, no response for 1024 cycles -> dmistat=2.
